// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT       = 21;
  localparam int unsigned DEFAULT_DIV_DEFAULT = 1_000_001;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // A divisor of zero has no meaning, so it is treated as divide-by-one.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == '0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow divisor, pending flag and registered tick/div_clk.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             pend,
  output logic             tick,
  output logic             div_clk
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             div_clk_q, div_clk_d;
  logic             wrap;

  // The divisor is never zero, so div_q - 1 cannot underflow and cnt_q stays below div_q.
  assign wrap = en && (cnt_q == div_q - ONE);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    div_clk_d = div_clk_q;

    if (en) begin
      if (wrap) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        div_clk_d = ~div_clk_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
    end

    // Swap only at a period boundary (or while idle) so no period mixes two divisors.
    if (pend_q && (wrap || !en)) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end

    if (load) begin
      shadow_d = load_div;
      pend_d   = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments; the reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_q     <= DIV_INIT;
      shadow_q  <= DIV_INIT;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign pend    = pend_q;
  assign tick    = tick_q;
  assign div_clk = div_clk_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: write decode, per-channel dividers and the write-ready mux.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT,
  localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] load;
  logic [CNT_W-1:0]  wr_div_clamped;
  logic              pend_sel;
  logic              wr_fire;

  assign wr_div_clamped = CNT_W'(clamp_div(32'(wr_div)));

  // Out-of-range channel numbers match nothing, so they read as ready and the write is dropped.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_W'(i)) pend_sel = pend[i];
    end
  end

  assign wr_ready = rst && !pend_sel;
  assign wr_fire  = wr_valid && wr_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = wr_fire && (wr_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[g]),
      .load    (load[g]),
      .load_div(wr_div_clamped),
      .pend    (pend[g]),
      .tick    (tick[g]),
      .div_clk (div_clk[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi against a next-wrap-time reference model.
module tb_clk_div_multi;

  // Small divisor width and default keep long periods simulable; five channels leave
  // select values 5..7 out of range.
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 10;
  localparam int DEF_DIV = 1001;
  localparam int CH_W    = 3;
  localparam int MAX_DIV = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              wr_valid = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic              wr_ready;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_clk;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .tick    (tick),
    .div_clk (div_clk)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each running channel remembers the absolute edge number of its next wrap.
  longint      now = 0;
  int unsigned m_d    [NUM_CH];
  int unsigned m_s    [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_run  [NUM_CH];
  bit          m_tick [NUM_CH];
  bit          m_dclk [NUM_CH];
  longint      m_due  [NUM_CH];

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_d[i] = DEF_DIV; m_s[i] = DEF_DIV; m_pend[i] = 0;
      m_run[i] = 0; m_tick[i] = 0; m_dclk[i] = 0; m_due[i] = 0;
    end
  endfunction

  function automatic bit model_ready();
    if (!rst) return 1'b0;
    if (int'(wr_ch) < NUM_CH) begin
      if (m_pend[wr_ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit acc;
    now++;
    if (!rst) begin
      model_reset();
      return;
    end
    acc = wr_valid && model_ready();
    for (int i = 0; i < NUM_CH; i++) begin
      bit wrap;
      wrap = 1'b0;
      if (ch_en[i]) begin
        if (!m_run[i]) begin
          m_run[i] = 1;
          m_due[i] = now + m_d[i] - 1;
        end
        if (now == m_due[i]) begin
          wrap = 1'b1;
          m_dclk[i] = !m_dclk[i];
        end
        m_tick[i] = wrap;
      end else begin
        m_run[i] = 0; m_tick[i] = 0; m_dclk[i] = 0;
      end
      if (m_pend[i] && (wrap || !ch_en[i])) begin
        m_d[i] = m_s[i];
        m_pend[i] = 0;
      end
      if (wrap) m_due[i] = now + m_d[i];
      if (acc && int'(wr_ch) == i) begin
        m_s[i] = (wr_div == '0) ? 1 : int'(wr_div);
        m_pend[i] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: ready is checked mid-cycle, registered outputs just after the edge.
  task automatic cycle();
    @(negedge clk);
    chk("wr_ready", wr_ready, model_ready());
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("tick[%0d]", i), tick[i], m_tick[i]);
      chk($sformatf("div_clk[%0d]", i), div_clk[i], m_dclk[i]);
    end
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (tick[ch] !== 1'b1 && n < budget);
    if (tick[ch] !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL tick_timeout ch=%0d observed=no_tick expected=tick within %0d", ch, budget);
    end
  endtask

  task automatic do_write(input int ch, input int div);
    wr_valid = 1'b1;
    wr_ch    = CH_W'(ch);
    wr_div   = CNT_W'(div);
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    model_reset();

    // Reset defaults.
    rst = 1'b0;
    repeat (3) cycle();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(wr_ready), 0);
    rst   = 1'b1;
    ch_en = 5'b00001;
    wait_tick(0, DEF_DIV + 20, n);
    chk("default_period", n, DEF_DIV);
    chk("default_divclk_rise", 32'(div_clk[0]), 1);
    chk("others_quiet", {tick[4:1], div_clk[4:1]}, 0);

    // Runtime divisor on a disabled channel.
    ch_en[0] = 1'b0;
    cycle();
    do_write(0, 5);
    cycle();
    ch_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(0, 20, n);
      chk("d5_period", n, 5);
    end

    // Glitch-free update mid-period.
    do_write(1, 8);
    cycle();
    ch_en[1] = 1'b1;
    wait_tick(1, 20, n);
    chk("d8_period", n, 8);
    cycle();
    cycle();
    do_write(1, 3);
    chk("ready_while_pend", 32'(wr_ready), 0);
    wait_tick(1, 20, n);
    chk("old_period_tail", n, 5);
    chk("ready_after_wrap", 32'(wr_ready), 1);
    for (int k = 0; k < 2; k++) begin
      wait_tick(1, 20, n);
      chk("d3_period", n, 3);
    end

    // Divisor zero behaves as one.
    do_write(3, 0);
    cycle();
    ch_en[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("d0_tick", 32'(tick[3]), 1);
      chk("d0_divclk", 32'(div_clk[3]), (k % 2 == 0) ? 1 : 0);
    end

    // Largest divisor.
    do_write(4, MAX_DIV);
    cycle();
    ch_en[4] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_tick(4, MAX_DIV + 20, n);
      chk("dmax_period", n, MAX_DIV);
    end
    ch_en[4] = 1'b0;

    // Out-of-range channel writes are accepted and dropped.
    wr_ch = 3'd5;
    cycle();
    chk("ready_oor", 32'(wr_ready), 1);
    do_write(5, 2);
    do_write(7, 0);
    wait_tick(1, 20, n);
    wait_tick(1, 20, n);
    chk("oor_no_effect", n, 3);

    // Disable mid-period with a pending write.
    do_write(2, 10);
    cycle();
    ch_en[2] = 1'b1;
    wait_tick(2, 20, n);
    chk("d10_period", n, 10);
    repeat (5) cycle();
    do_write(2, 4);
    ch_en[2] = 1'b0;
    cycle();
    chk("dis_tick", 32'(tick[2]), 0);
    chk("dis_divclk", 32'(div_clk[2]), 0);
    chk("dis_pend_cleared", 32'(wr_ready), 1);
    ch_en[2] = 1'b1;
    wait_tick(2, 20, n);
    chk("reenable_period", n, 4);

    // Reset with a pending write and div_clk high.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      found = (tick[1] === 1'b1) && (div_clk[1] === 1'b1);
    end
    chk("found_high_phase", 32'(found), 1);
    do_write(1, 9);
    chk("pend_before_rst", 32'(wr_ready), 0);
    chk("divclk_before_rst", 32'(div_clk[1]), 1);
    rst = 1'b0;
    cycle();
    chk("midrst_tick", 32'(tick), 0);
    chk("midrst_divclk", 32'(div_clk), 0);
    chk("midrst_ready", 32'(wr_ready), 0);
    cycle();
    rst   = 1'b1;
    ch_en = 5'b00010;
    wait_tick(1, DEF_DIV + 20, n);
    chk("post_rst_default", n, DEF_DIV);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(39) == 0) ch_en[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      rst      = ($urandom_range(399) != 0);
      wr_valid = ($urandom_range(3) == 0);
      wr_ch    = CH_W'($urandom_range(7));
      wr_div   = CNT_W'($urandom_range(12));
      cycle();
    end
    wr_valid = 1'b0;
    rst      = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
